// File: rtl/mm_tile_controller.sv
`default_nettype none
// ============================================================================
// Module      : mm_tile_controller
// Description : Sequences an SA_SIZE x SA_SIZE systolic array over an
//               MxK by KxN product. Generates A/B read addresses, PE
//               control strobes, and P write-back (optionally
//               read-modify-write) addresses. Supports abort.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mm_tile_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int SA_SIZE    = 8,
    parameter int OUTPUT_LAT = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       accum_i,
    input  logic [ADDR_WIDTH-1:0]      m_i,
    input  logic [ADDR_WIDTH-1:0]      k_i,
    input  logic [ADDR_WIDTH-1:0]      n_i,
    input  logic [ADDR_WIDTH-1:0]      base_addra_i,
    input  logic [ADDR_WIDTH-1:0]      base_addrb_i,
    input  logic [ADDR_WIDTH-1:0]      base_addrp_i,
    output logic                       busy_o,
    output logic                       valid_o,
    output logic                       pe_clr_o,
    output logic                       pe_we_o,
    output logic                       ensys_o,
    output logic                       bubble_o,
    output logic                       ena_o,
    output logic                       enb_o,
    output logic [ADDR_WIDTH-1:0]      addra_o,
    output logic [ADDR_WIDTH-1:0]      addrb_o,
    output logic                       enp_o,
    output logic                       wep_o,
    output logic [ADDR_WIDTH-1:0]      addrp_o,
    output logic [$clog2(SA_SIZE)-1:0] wordp_sel_o,
    output logic                       accum_o
);

    localparam int LOG2S  = $clog2(SA_SIZE);
    localparam int SR_LEN = SA_SIZE + OUTPUT_LAT;
    localparam logic [ADDR_WIDTH-1:0] S_LEN   = ADDR_WIDTH'(SA_SIZE);
    localparam logic [ADDR_WIDTH-1:0] S2_LEN  = ADDR_WIDTH'(2 * SA_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [LOG2S:0]        S_WORDS = (LOG2S + 1)'(SA_SIZE);

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_BUSY = 2'd1, M_DONE = 2'd2} main_state_e;
    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_BUSY = 2'd1, RD_DONE = 2'd2} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_BURST = 2'd1, WR_DONE = 2'd2} wr_state_e;

    main_state_e main_q, main_d;
    rd_state_e   rd_state_q, rd_state_d;
    wr_state_e   wr_state_q, wr_state_d;

    // Latched run configuration
    logic                  acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_p_q, base_p_d;

    // Reader counters: cycle within batch, row/column batch, row/column offsets (r*k, c*k)
    logic [ADDR_WIDTH-1:0] rd_j_q, rd_j_d, rd_r_q, rd_r_d, rd_c_q, rd_c_d;
    logic [ADDR_WIDTH-1:0] ra_off_q, ra_off_d, cb_off_q, cb_off_d;

    // Writer state: pe_we delay line, word index, RMW phase, column batch, word counter
    logic [SR_LEN-1:0]     sr_q, sr_d;
    logic [LOG2S-1:0]      idx_q, idx_d;
    logic                  ph_q, ph_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d, p_q, p_d;
    logic                  burst_nxt;

    // Registered outputs
    logic                  pe_clr_q, pe_clr_d, pe_we_q, pe_we_d, ensys_q, ensys_d, bubble_q, bubble_d;
    logic                  ena_q, ena_d, enp_q, enp_d, wep_q, wep_d, accum_out_q, accum_out_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d, addrp_q, addrp_d;
    logic [LOG2S-1:0]      wsel_q, wsel_d;

    // Derived run geometry
    logic                  zero_dim, clear;
    logic [ADDR_WIDTH-1:0] r_cnt, c_cnt, l_len;
    logic [LOG2S:0]        w_len;

    // Batch counts, batch length, burst width of the column batch being written, and sub-FSM clear
    always_comb begin
        zero_dim = (m_q == '0) || (k_q == '0) || (n_q == '0);
        r_cnt    = (m_q >> LOG2S) + ADDR_WIDTH'(|m_q[LOG2S-1:0]);
        c_cnt    = (n_q >> LOG2S) + ADDR_WIDTH'(|n_q[LOG2S-1:0]);
        l_len    = acc_q ? ((k_q > S2_LEN) ? k_q : S2_LEN) : ((k_q > S_LEN) ? k_q : S_LEN);
        w_len    = ((col_q == c_cnt - ONE) && (n_q[LOG2S-1:0] != '0)) ? {1'b0, n_q[LOG2S-1:0]} : S_WORDS;
        // Sub-FSMs only run while the main FSM is BUSY; an abort wipes them the next cycle
        clear    = (main_q == M_BUSY) ? abort_i : 1'b1;
    end

    // Main FSM and configuration latch
    always_comb begin
        main_d   = main_q;
        acc_d    = acc_q;
        m_d      = m_q;
        k_d      = k_q;
        n_d      = n_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_p_d = base_p_q;
        unique case (main_q)
            M_IDLE: if (start_i) begin
                main_d   = M_BUSY;
                acc_d    = accum_i;
                m_d      = m_i;
                k_d      = k_i;
                n_d      = n_i;
                base_a_d = base_addra_i;
                base_b_d = base_addrb_i;
                base_p_d = base_addrp_i;
            end
            M_BUSY: begin
                if (abort_i) main_d = M_IDLE;
                else if (zero_dim || (rd_state_q == RD_DONE && wr_state_q == WR_DONE)) main_d = M_DONE;
            end
            M_DONE: if (!start_i) main_d = M_IDLE;
            default: main_d = M_IDLE;
        endcase
    end

    // Reader: row-major batch walk, A/B addresses and PE strobes for the next cycle
    always_comb begin
        rd_state_d = rd_state_q;
        rd_j_d     = rd_j_q;
        rd_r_d     = rd_r_q;
        rd_c_d     = rd_c_q;
        ra_off_d   = ra_off_q;
        cb_off_d   = cb_off_q;
        unique case (rd_state_q)
            RD_IDLE: if (!zero_dim) begin
                rd_state_d = RD_BUSY;
                rd_j_d     = '0;
                rd_r_d     = '0;
                rd_c_d     = '0;
                ra_off_d   = '0;
                cb_off_d   = '0;
            end
            RD_BUSY: begin
                if (rd_j_q == l_len - ONE) begin
                    rd_j_d = '0;
                    if (rd_c_q == c_cnt - ONE) begin
                        rd_c_d   = '0;
                        cb_off_d = '0;
                        if (rd_r_q == r_cnt - ONE) begin
                            rd_state_d = RD_DONE;
                        end else begin
                            rd_r_d   = rd_r_q + ONE;
                            ra_off_d = ra_off_q + k_q;
                        end
                    end else begin
                        rd_c_d   = rd_c_q + ONE;
                        cb_off_d = cb_off_q + k_q;
                    end
                end else begin
                    rd_j_d = rd_j_q + ONE;
                end
            end
            RD_DONE: rd_state_d = RD_DONE;
            default: rd_state_d = RD_IDLE;
        endcase
        if (clear) begin
            rd_state_d = RD_IDLE;
            rd_j_d     = '0;
            rd_r_d     = '0;
            rd_c_d     = '0;
            ra_off_d   = '0;
            cb_off_d   = '0;
        end
        ena_d    = (rd_state_d == RD_BUSY) && (rd_j_d < k_q);
        addra_d  = ena_d ? base_a_q + ra_off_d + rd_j_d : '0;
        addrb_d  = ena_d ? base_b_q + cb_off_d + rd_j_d : '0;
        pe_we_d  = (rd_state_d == RD_BUSY) && (rd_j_d == k_q - ONE);
        pe_clr_d = !clear && (rd_state_q == RD_BUSY) && (rd_j_q == '0);
        bubble_d = !clear && (rd_state_q == RD_BUSY) && (rd_j_q >= k_q);
        ensys_d  = !clear && (rd_state_q == RD_BUSY);
    end

    // Writer: delayed pe_we pulses launch P bursts (plain write or read-then-write per word)
    always_comb begin
        sr_d       = {sr_q[SR_LEN-2:0], pe_we_q};
        wr_state_d = wr_state_q;
        idx_d      = idx_q;
        ph_d       = ph_q;
        col_d      = col_q;
        p_d        = p_q + ADDR_WIDTH'(wep_q);
        burst_nxt  = (wr_state_q == WR_BURST);
        if (wr_state_q == WR_BURST) begin
            if (acc_q && !ph_q) begin
                ph_d = 1'b1;
            end else begin
                ph_d = 1'b0;
                if ({1'b0, idx_q} == w_len - (LOG2S + 1)'(1)) begin
                    burst_nxt = 1'b0;
                    idx_d     = '0;
                    col_d     = (col_q == c_cnt - ONE) ? '0 : col_q + ONE;
                end else begin
                    idx_d = idx_q + LOG2S'(1);
                end
            end
        end
        // A new burst may start in the same cycle the previous one ends
        if (!burst_nxt && sr_q[SR_LEN-1]) begin
            burst_nxt = 1'b1;
            idx_d     = '0;
            ph_d      = 1'b0;
        end
        if (wr_state_q != WR_DONE) begin
            if (burst_nxt) wr_state_d = WR_BURST;
            else if (rd_state_q == RD_DONE && sr_q == '0) wr_state_d = WR_DONE;
            else wr_state_d = WR_IDLE;
        end
        if (clear) begin
            sr_d       = '0;
            wr_state_d = WR_IDLE;
            idx_d      = '0;
            ph_d       = 1'b0;
            col_d      = '0;
            p_d        = '0;
            burst_nxt  = 1'b0;
        end
        enp_d       = burst_nxt;
        wep_d       = burst_nxt && (!acc_q || ph_d);
        accum_out_d = burst_nxt && acc_q && ph_d;
        addrp_d     = burst_nxt ? base_p_q + p_d : '0;
        wsel_d      = burst_nxt ? idx_d : '0;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q      <= M_IDLE;
            rd_state_q  <= RD_IDLE;
            wr_state_q  <= WR_IDLE;
            acc_q       <= 1'b0;
            m_q         <= '0;
            k_q         <= '0;
            n_q         <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_p_q    <= '0;
            rd_j_q      <= '0;
            rd_r_q      <= '0;
            rd_c_q      <= '0;
            ra_off_q    <= '0;
            cb_off_q    <= '0;
            sr_q        <= '0;
            idx_q       <= '0;
            ph_q        <= 1'b0;
            col_q       <= '0;
            p_q         <= '0;
            pe_clr_q    <= 1'b0;
            pe_we_q     <= 1'b0;
            ensys_q     <= 1'b0;
            bubble_q    <= 1'b0;
            ena_q       <= 1'b0;
            enp_q       <= 1'b0;
            wep_q       <= 1'b0;
            accum_out_q <= 1'b0;
            addra_q     <= '0;
            addrb_q     <= '0;
            addrp_q     <= '0;
            wsel_q      <= '0;
        end else begin
            main_q      <= main_d;
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            acc_q       <= acc_d;
            m_q         <= m_d;
            k_q         <= k_d;
            n_q         <= n_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_p_q    <= base_p_d;
            rd_j_q      <= rd_j_d;
            rd_r_q      <= rd_r_d;
            rd_c_q      <= rd_c_d;
            ra_off_q    <= ra_off_d;
            cb_off_q    <= cb_off_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            ph_q        <= ph_d;
            col_q       <= col_d;
            p_q         <= p_d;
            pe_clr_q    <= pe_clr_d;
            pe_we_q     <= pe_we_d;
            ensys_q     <= ensys_d;
            bubble_q    <= bubble_d;
            ena_q       <= ena_d;
            enp_q       <= enp_d;
            wep_q       <= wep_d;
            accum_out_q <= accum_out_d;
            addra_q     <= addra_d;
            addrb_q     <= addrb_d;
            addrp_q     <= addrp_d;
            wsel_q      <= wsel_d;
        end
    end

    assign busy_o      = (main_q == M_BUSY);
    assign valid_o     = (main_q == M_DONE);
    assign pe_clr_o    = pe_clr_q;
    assign pe_we_o     = pe_we_q;
    assign ensys_o     = ensys_q;
    assign bubble_o    = bubble_q;
    assign ena_o       = ena_q;
    assign enb_o       = ena_q;
    assign addra_o     = addra_q;
    assign addrb_o     = addrb_q;
    assign enp_o       = enp_q;
    assign wep_o       = wep_q;
    assign addrp_o     = addrp_q;
    assign wordp_sel_o = wsel_q;
    assign accum_o     = accum_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mm_tile_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_tile_controller
// Description : Directed scoreboard bench for mm_tile_controller. Expected
//               A/B reads and P accesses (with their cycle numbers) are
//               queued when a run is started and popped as the DUT emits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_tile_controller;

    localparam int AW  = 16;
    localparam int S   = 8;
    localparam int LAT = 2;
    localparam int SW  = $clog2(S);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0, abort_i = 1'b0, accum_i = 1'b0;
    logic [AW-1:0] m_i = '0, k_i = '0, n_i = '0;
    logic [AW-1:0] base_addra_i = '0, base_addrb_i = '0, base_addrp_i = '0;
    logic          busy_o, valid_o, pe_clr_o, pe_we_o, ensys_o, bubble_o;
    logic          ena_o, enb_o, enp_o, wep_o, accum_o;
    logic [AW-1:0] addra_o, addrb_o, addrp_o;
    logic [SW-1:0] wordp_sel_o;

    mm_tile_controller #(.ADDR_WIDTH(AW), .SA_SIZE(S), .OUTPUT_LAT(LAT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .accum_i(accum_i), .m_i(m_i), .k_i(k_i), .n_i(n_i),
        .base_addra_i(base_addra_i), .base_addrb_i(base_addrb_i), .base_addrp_i(base_addrp_i),
        .busy_o(busy_o), .valid_o(valid_o), .pe_clr_o(pe_clr_o), .pe_we_o(pe_we_o),
        .ensys_o(ensys_o), .bubble_o(bubble_o), .ena_o(ena_o), .enb_o(enb_o),
        .addra_o(addra_o), .addrb_o(addrb_o), .enp_o(enp_o), .wep_o(wep_o),
        .addrp_o(addrp_o), .wordp_sel_o(wordp_sel_o), .accum_o(accum_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int cyc; logic [AW-1:0] a; logic [AW-1:0] b; } rd_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [SW-1:0] sel; logic we; logic acc; } wr_t;

    rd_t rdq[$];
    wr_t wrq[$];
    int  n_vec  = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {2'b00, busy_o, valid_o, pe_clr_o, pe_we_o, ensys_o, bubble_o, ena_o, enb_o,
                enp_o, wep_o, accum_o, addra_o, addrb_o, addrp_o, wordp_sel_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Start a run at cycle 0 (start_i high for that one cycle), then track it.
    task automatic run_case(input int m, input int k, input int n, input bit acc,
                            input int ba, input int bb, input int bp, input int abort_at);
        int  L, R, C, b, p, pe, w, last_x, exp_valid, limit, got_valid;
        int  n_we, n_clr, n_bub, n_sys, idle_bad, late_bad, extra;
        bit  zero;
        rd_t er;
        wr_t ew;
        rdq.delete();
        wrq.delete();
        zero   = (m == 0) || (k == 0) || (n == 0);
        L      = acc ? ((k > 2 * S) ? k : 2 * S) : ((k > S) ? k : S);
        R      = (m + S - 1) / S;
        C      = (n + S - 1) / S;
        b      = 0;
        p      = 0;
        last_x = 0;
        if (!zero) begin
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    for (int j = 0; j < k; j++)
                        rdq.push_back('{2 + b * L + j, AW'(ba + r * k + j), AW'(bb + c * k + j)});
                    pe = 2 + b * L + k - 1;
                    w  = (c == C - 1 && (n % S) != 0) ? (n % S) : S;
                    for (int i = 0; i < w; i++) begin
                        if (acc) begin
                            wrq.push_back('{pe + S + LAT + 1 + 2 * i, AW'(bp + p), SW'(i), 1'b0, 1'b0});
                            wrq.push_back('{pe + S + LAT + 2 + 2 * i, AW'(bp + p), SW'(i), 1'b1, 1'b1});
                            last_x = pe + S + LAT + 2 + 2 * i;
                        end else begin
                            wrq.push_back('{pe + S + LAT + 1 + i, AW'(bp + p), SW'(i), 1'b1, 1'b0});
                            last_x = pe + S + LAT + 1 + i;
                        end
                        p++;
                    end
                    b++;
                end
            end
        end
        exp_valid = zero ? 2 : last_x + 2;
        limit     = (abort_at >= 0) ? abort_at + 40 : exp_valid + 6;
        got_valid = -1;
        n_we = 0; n_clr = 0; n_bub = 0; n_sys = 0; idle_bad = 0; late_bad = 0; extra = 0;

        accum_i      = acc;
        m_i          = AW'(m);
        k_i          = AW'(k);
        n_i          = AW'(n);
        base_addra_i = AW'(ba);
        base_addrb_i = AW'(bb);
        base_addrp_i = AW'(bp);
        start_i      = 1'b1;

        for (int cyc = 0; cyc <= limit; cyc++) begin
            if (cyc == 0) chk("busy_before_start", 64'(busy_o), 64'(0));
            if (cyc == 1) chk("busy_at_T1", 64'(busy_o), 64'(1));
            if (abort_at >= 0 && cyc == abort_at + 1) chk("outputs_after_abort", all_out(), 64'(0));
            if (abort_at >= 0 && cyc > abort_at) begin
                if (busy_o || valid_o || ena_o || enb_o || enp_o || wep_o) late_bad++;
            end else begin
                if (ena_o) begin
                    if (rdq.size() == 0) extra++;
                    else begin
                        er = rdq.pop_front();
                        chk("rd_cycle", 64'(cyc), 64'(er.cyc));
                        chk("addra", 64'(addra_o), 64'(er.a));
                        chk("addrb_en", 64'({enb_o, addrb_o}), 64'({1'b1, er.b}));
                    end
                end else if (enb_o || addra_o != '0 || addrb_o != '0) idle_bad++;
                if (enp_o) begin
                    if (wrq.size() == 0) extra++;
                    else begin
                        ew = wrq.pop_front();
                        chk("p_cycle", 64'(cyc), 64'(ew.cyc));
                        chk("addrp", 64'(addrp_o), 64'(ew.addr));
                        chk("wordp_sel", 64'(wordp_sel_o), 64'(ew.sel));
                        chk("wep_accum", 64'({wep_o, accum_o}), 64'({ew.we, ew.acc}));
                    end
                end else if (wep_o || accum_o || addrp_o != '0 || wordp_sel_o != '0) idle_bad++;
                n_we  += int'(pe_we_o);
                n_clr += int'(pe_clr_o);
                n_bub += int'(bubble_o);
                n_sys += int'(ensys_o);
                if (valid_o && got_valid < 0) got_valid = cyc;
            end
            if (cyc == 1) begin
                start_i      = 1'b0;
                accum_i      = ~acc;
                m_i          = AW'($urandom);
                k_i          = AW'($urandom);
                n_i          = AW'($urandom);
                base_addra_i = AW'($urandom);
                base_addrb_i = AW'($urandom);
                base_addrp_i = AW'($urandom);
            end
            abort_i = (cyc == abort_at);
            tick();
        end
        abort_i = 1'b0;

        if (abort_at >= 0) begin
            chk("activity_after_abort", 64'(late_bad), 64'(0));
        end else begin
            chk("valid_cycle", 64'(got_valid), 64'(exp_valid));
            chk("reads_missing", 64'(rdq.size()), 64'(0));
            chk("p_access_missing", 64'(wrq.size()), 64'(0));
            chk("unexpected_access", 64'(extra), 64'(0));
            chk("pe_we_count", 64'(n_we), 64'(zero ? 0 : R * C));
            chk("pe_clr_count", 64'(n_clr), 64'(zero ? 0 : R * C));
            chk("bubble_count", 64'(n_bub), 64'(zero ? 0 : R * C * (L - k)));
            chk("ensys_count", 64'(n_sys), 64'(zero ? 0 : R * C * L));
            chk("undriven_nonzero", 64'(idle_bad), 64'(0));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outputs", all_out(), 64'(0));
        rst_ni = 1'b1;
        tick();
        chk("post_reset_outputs", all_out(), 64'(0));

        run_case(8, 8, 8, 1'b0, 'h0, 'h100, 'h200, -1);
        run_case(8, 3, 8, 1'b0, 'h0, 'h100, 'h200, -1);
        run_case(8, 8, 12, 1'b0, 'h40, 'h140, 'h240, -1);
        run_case(8, 8, 16, 1'b0, 'h0, 'h100, 'h200, -1);
        run_case(8, 8, 8, 1'b1, 'h0, 'h100, 'h200, -1);
        run_case(16, 16, 16, 1'b0, 'h0, 'h100, 'h300, 10);
        run_case(8, 8, 8, 1'b0, 'h0, 'h100, 'h300, -1);
        run_case(16, 5, 8, 1'b0, 'hFFFA, 'hFFF0, 'hFFFC, -1);
        run_case(0, 8, 8, 1'b0, 'h0, 'h100, 'h200, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
